// File: rtl/jram_pkg.sv
// rtl/jram_pkg.sv - shared defaults and helpers for the jram block
package jram_pkg;
   localparam int JRAM_W_DEF   = 8;
   localparam int JRAM_AW_DEF  = 8;
   localparam int JRAM_RST_VAL = 0;

   function automatic int jram_depth(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/jram_if.sv
// rtl/jram_if.sv - strobe/data interface of the jram block (bos stays a plain inout)
interface jram_if #(
   parameter int W = jram_pkg::JRAM_W_DEF
);
   logic [W-1:0] bis;
   logic         wsa;
   logic         ws;
   logic         we;
   logic         wov;

   modport master (output bis, wsa, ws, we, input wov);
   modport slave  (input bis, wsa, ws, we, output wov);
endinterface

// File: rtl/jregn.sv
// rtl/jregn.sv - W-bit register with sync active-low reset and load enable
import jram_pkg::*;

module jregn #(
   parameter int W = JRAM_W_DEF
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_ld,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rstn)
         r_q <= W'(JRAM_RST_VAL);
      else if (i_ld)
         r_q <= i_d;
   end

   assign o_q = r_q;
endmodule

// File: rtl/jram.sv
// rtl/jram.sv - clocked RAM with internal MAR and tri-state read bus.
// JRAM_AUTOINC_EN: ws/we without wsa post-increments the MAR.
import jram_pkg::*;

module jram #(
   parameter int W  = JRAM_W_DEF,
   parameter int AW = JRAM_AW_DEF
) (
   input  logic          wclk,
   input  logic          wrstn,
   jram_if.slave         bus,
   inout  wire  [W-1:0]  bos
);
   localparam int DEPTH = jram_depth(AW);

   logic [W-1:0]  r_mem [DEPTH];
   logic          r_wov;
   logic [AW-1:0] w_mar;
   logic [AW-1:0] w_mar_d;
   logic          w_mar_ld;
   logic [AW-1:0] w_addr_in;
   logic [W-1:0]  w_rd_q;

   // Cast zero-extends when W<AW and truncates when W>AW.
   assign w_addr_in = AW'(bus.bis);

`ifdef JRAM_AUTOINC_EN
   assign w_mar_ld = bus.wsa | bus.ws | bus.we;
   assign w_mar_d  = bus.wsa ? w_addr_in : w_mar + AW'(1);
`else
   assign w_mar_ld = bus.wsa;
   assign w_mar_d  = w_addr_in;
`endif

   jregn #(.W(AW)) u_mar (
      .i_clk  (wclk),
      .i_rstn (wrstn),
      .i_ld   (w_mar_ld),
      .i_d    (w_mar_d),
      .o_q    (w_mar)
   );

   // All accesses in one edge see the pre-edge MAR, so reads are read-before-write.
   jregn #(.W(W)) u_rd (
      .i_clk  (wclk),
      .i_rstn (wrstn),
      .i_ld   (bus.we),
      .i_d    (r_mem[w_mar]),
      .o_q    (w_rd_q)
   );

   always_ff @(posedge wclk) begin
      if (!wrstn) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= W'(JRAM_RST_VAL);
      end else if (bus.ws) begin
         r_mem[w_mar] <= bus.bis;
      end
   end

   always_ff @(posedge wclk) begin
      if (!wrstn)
         r_wov <= 1'b0;
      else
         r_wov <= bus.we;
   end

   assign bus.wov = r_wov;
   assign bos     = r_wov ? w_rd_q : {W{1'bz}};
endmodule

// File: tb/tb_jram.sv
// tb/tb_jram.sv - self-checking bench for jram (W=8, AW=4) against a behavioural model
module tb_jram;
   localparam int W  = 8;
   localparam int AW = 4;
   localparam int D  = 1 << AW;

   logic   clk;
   logic   rstn;
   wire [W-1:0] bos;

   jram_if #(.W(W)) bus ();

   jram #(.W(W), .AW(AW)) dut (
      .wclk  (clk),
      .wrstn (rstn),
      .bus   (bus),
      .bos   (bos)
   );

   // Undriven bus reads as all ones, so a stray driver shows up.
   pullup pu_bos (bos);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int m_mem [D];
   int m_mar;
   int m_rd;
   bit m_wov;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit sa, input bit s, input bit e, input int b);
      int old;
      if (!r) begin
         for (int i = 0; i < D; i++) m_mem[i] = 0;
         m_mar = 0; m_rd = 0; m_wov = 0;
      end else begin
         old = m_mar;
         if (e) m_rd = m_mem[old];
         m_wov = e;
         if (s) m_mem[old] = b;
         if (sa) m_mar = b % D;
`ifdef JRAM_AUTOINC_EN
         else if (s || e) m_mar = (old + 1) % D;
`endif
      end
   endtask

   task automatic cycle(input bit r, input bit sa, input bit s, input bit e, input int b);
      rstn    = r;
      bus.wsa = sa;
      bus.ws  = s;
      bus.we  = e;
      bus.bis = W'(b);
      @(posedge clk);
      model_step(r, sa, s, e, b);
      #1;
      chk("wov", {31'd0, bus.wov}, {31'd0, m_wov});
      chk("bos", {24'd0, bos}, m_wov ? 32'(m_rd) : 32'hFF);
   endtask

   initial begin
      rstn = 1'b0; bus.wsa = 1'b0; bus.ws = 1'b0; bus.we = 1'b0; bus.bis = '0;
      for (int i = 0; i < D; i++) m_mem[i] = 0;
      m_mar = 0; m_rd = 0; m_wov = 0;
      #2;

      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 0);
      chk("rst_read", {24'd0, bos}, 32'h00);
      cycle(1, 0, 0, 0, 0);
      chk("rst_z", {24'd0, bos}, 32'hFF);

      cycle(1, 1, 0, 0, 8'h05);
      cycle(1, 0, 1, 0, 8'hA5);
      cycle(1, 1, 0, 0, 8'h05);
      cycle(1, 0, 0, 1, 0);
      chk("wr_rd", {24'd0, bos}, 32'hA5);
      cycle(1, 1, 0, 0, 8'h06);
      cycle(1, 0, 0, 1, 0);
      chk("rd_empty", {24'd0, bos}, 32'h00);

      cycle(1, 1, 0, 0, 8'h03);
      cycle(1, 0, 1, 0, 8'h11);
      cycle(1, 1, 0, 0, 8'h03);
      cycle(1, 0, 1, 1, 8'h22);
      chk("rbw_old", {24'd0, bos}, 32'h11);
      cycle(1, 1, 0, 0, 8'h03);
      cycle(1, 0, 0, 1, 0);
      chk("rbw_new", {24'd0, bos}, 32'h22);
      cycle(1, 1, 1, 0, 8'h07);
      cycle(1, 1, 0, 0, 8'h03);
      cycle(1, 0, 0, 1, 0);
      chk("wsa_ws", {24'd0, bos}, 32'h07);

      cycle(1, 1, 0, 0, 8'hFF);
      cycle(1, 0, 1, 0, 8'h3C);
      cycle(1, 1, 0, 0, 8'h0F);
      cycle(1, 0, 0, 1, 0);
      chk("wrap", {24'd0, bos}, 32'h3C);

      cycle(1, 1, 0, 0, 8'h0E);
      cycle(1, 0, 1, 0, 8'h01);
      cycle(1, 0, 1, 0, 8'h02);
      cycle(1, 0, 1, 0, 8'h03);
      cycle(1, 1, 0, 0, 8'h0E);
`ifdef JRAM_AUTOINC_EN
      cycle(1, 0, 0, 1, 0); chk("ainc0", {24'd0, bos}, 32'h01);
      cycle(1, 0, 0, 1, 0); chk("ainc1", {24'd0, bos}, 32'h02);
      cycle(1, 0, 0, 1, 0); chk("ainc2", {24'd0, bos}, 32'h03);
`else
      cycle(1, 0, 0, 1, 0); chk("ainc0", {24'd0, bos}, 32'h03);
      cycle(1, 0, 0, 1, 0); chk("ainc1", {24'd0, bos}, 32'h03);
      cycle(1, 0, 0, 1, 0); chk("ainc2", {24'd0, bos}, 32'h03);
`endif

      cycle(1, 1, 0, 0, 8'h0F);
      cycle(1, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      chk("midrd_wov", {31'd0, bus.wov}, 32'd0);
      chk("midrd_z", {24'd0, bos}, 32'hFF);
      cycle(1, 0, 0, 1, 0);
      chk("post_rst", {24'd0, bos}, 32'h00);

      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 39) != 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 0),
               int'($urandom_range(0, 255)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/jram.md
Name: jram

Overview:
- Parametrised, clocked RAM block for the CPU datapath.
- Holds 2^AW words of W bits each.
- Contains an internal memory address register (MAR) loaded from the bus.
- Writes go to the word the MAR selects; reads drive that word onto a tri-state output bus one cycle after the enable request.
- Successor to the fixed 8-bit latch-based byte/register storage: edge-triggered, any width and depth, optional auto-increment.

Parameters:
- W, 8, data word width in bits (≥1)
- AW, 8, address width; depth = 2^AW words (1..10)

Ports:
- wclk  input  1  clock; all state changes on rising edge
- wrstn  input  1  synchronous reset, active-low, sampled on rising wclk
- bis  input  W  input data bus; low AW bits are used as the address when wsa=1
- wsa  input  1  set-address strobe: load MAR from bis[AW-1:0]
- ws  input  1  set strobe: write bis into mem[MAR]
- we  input  1  enable strobe: request read of mem[MAR]
- bos  inout  W  output bus; drives read data when wov=1, else high-Z
- wov  output  1  output valid; bos is driven this cycle

Behaviour:
- Reset (wrstn=0 at edge):
  - MAR=0, read register=0, wov=0, bos=Z.
  - All memory words cleared to 0.
  - Reset overrides all strobes in that cycle.
- Address load: wsa=1 at edge n → MAR=bis[AW-1:0] from edge n. If W<AW, bis is zero-extended.
- Write: ws=1 at edge n → mem[MAR_old]=bis, where MAR_old is the MAR value before edge n.
- Read:
  - we=1 at edge n → read register=mem[MAR_old] and wov=1 from edge n until edge n+1.
  - Latency is 1 cycle; back-to-back we gives continuous wov.
  - we=0 at edge → wov=0; bos returns to Z.
  - The read register holds its last value while wov=0.
- Simultaneous strobes, all in one edge, all using MAR_old:
  - wsa+ws: write goes to MAR_old, then MAR updates.
  - wsa+we: read uses MAR_old.
  - ws+we: read-before-write, so bos shows the old word; the new word is visible on the next read.
  - wsa+ws+we: all three rules apply together.
- bos drive: bos = wov ? read register : all-Z. The block never drives bos while wov=0.
- Address wrap: MAR is exactly AW bits; values wrap modulo 2^AW with no error flag.
- Reset mid-read: wrstn=0 on the edge after we forces wov=0 immediately at that edge and discards the read.
- No strobe: all state holds.

Optional Feature:
- Macro: JRAM_AUTOINC_EN.
- Defined:
  - Any edge with ws=1 or we=1 and wsa=0 sets MAR=MAR_old+1 (mod 2^AW).
  - If wsa=1, the wsa load wins and no increment occurs.
  - The increment is applied after the access, so the access uses MAR_old.
- Undefined: MAR changes only on wsa or reset. ws/we never alter MAR.

Decomposition:
- Package jram_pkg:
  - default W/AW constants
  - depth function (2^AW)
  - localparam of the reset word value (0)
- Natural sub-module: jregn #(W), a clocked W-bit register with sync active-low reset and load enable.
  - Instantiated for the MAR (width AW) and the read register.
- Memory array and decode stay inline in jram.

Test Plan:
- Reset, then W=8, AW=4: hold wrstn=0 one cycle, release; we=1 → wov=1 next cycle, bos=0x00; with we=0, bos=Z.
- Write/read: wsa with bis=0x05; ws with bis=0xA5; we → next cycle bos=0xA5, wov=1. wsa bis=0x06; we → bos=0x00.
- Simultaneous strobes: MAR=3, mem[3]=0x11; one edge with ws=1, we=1, bis=0x22 → bos=0x11 next cycle; a following we → 0x22. wsa+ws with bis=0x07 → write lands at 3, MAR becomes 7.
- Address wrap and truncation: wsa with bis=0xFF (AW=4) → MAR=0xF; write 0x3C; wsa bis=0x0F; read → 0x3C.
- Auto-increment (JRAM_AUTOINC_EN defined):
  - wsa bis=0x0E; ws 0x01; ws 0x02; ws 0x03 → mem[E]=1, mem[F]=2, mem[0]=3.
  - wsa 0x0E, then three we cycles → bos sequence 1, 2, 3.
  - Without the macro, the same stimulus gives mem[E]=3 and three reads of 3.
- Reset mid-read: we=1 at edge n, wrstn=0 at edge n+1 → wov=0 and bos=Z after edge n+1; a following read at MAR 0 → 0x00.
